// File: rtl/dpram_loader_pkg.sv
// Shared types and constants for the dual-port RAM stream loader.
package dpram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned CHECKSUM_W = 16;

  // Bytes per RAM word.
  function automatic int unsigned bpw(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dpram_stream_loader_if.sv
// Byte stream valid/ready bus feeding the loader.
interface dpram_stream_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dpram_byte_packer.sv
// Little-endian byte-to-word packer with zero padding of unfilled upper lanes.
module dpram_byte_packer
  import dpram_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic                  last_byte,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word_c,
  output logic                  complete_c
);

  localparam int unsigned BPW    = bpw(DATA_WIDTH);
  localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  logic [LANE_W-1:0]     lane_q;
  logic [DATA_WIDTH-1:0] acc_q;

  // acc_q is cleared after every word, so lanes above the current one are already zero.
  always_comb begin
    word_c = acc_q;
    for (int unsigned i = 0; i < BPW; i++) begin
      if (LANE_W'(i) == lane_q) word_c[8*i +: 8] = byte_data;
    end
    complete_c = byte_valid && (last_byte || (lane_q == LAST_LANE));
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else if (byte_valid) begin
      if (complete_c) begin
        lane_q <= '0;
        acc_q  <= '0;
      end else begin
        lane_q <= lane_q + LANE_W'(1);
        acc_q  <= word_c;
      end
    end
  end

endmodule

// File: rtl/dpram_stream_loader.sv
// Streams bytes into one dual-port RAM write port at incrementing addresses.
// Optional running byte checksum output: define DPRAM_STREAM_LOADER_CHECKSUM_EN.
module dpram_stream_loader
  import dpram_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  dpram_stream_loader_if.slave     s,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   words_written
`ifdef DPRAM_STREAM_LOADER_CHECKSUM_EN
  ,
  output logic [CHECKSUM_W-1:0]    checksum
`endif
);

  localparam logic [ADDRESS_WIDTH:0] WORDS_MAX = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  state_e                   state_q, state_d;
  logic                     s_ready_q;
  logic [ADDRESS_WIDTH-1:0] ptr_q;
  logic [LEN_WIDTH-1:0]     remaining_q;
  logic                     start_acc;
  logic                     hs;
  logic                     last_byte;
  logic [DATA_WIDTH-1:0]    word_c;
  logic                     complete_c;

  // A byte arriving alongside abort is dropped with the rest of the partial word.
  assign hs        = s.s_valid && s_ready_q && !abort;
  assign last_byte = (remaining_q == LEN_WIDTH'(1));
  assign s.s_ready = s_ready_q;

  dpram_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (start_acc || abort),
    .byte_valid (hs),
    .last_byte  (last_byte),
    .byte_data  (s.s_data),
    .word_c     (word_c),
    .complete_c (complete_c)
  );

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !abort) begin
          start_acc = 1'b1;
          state_d   = (length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort)                state_d = IDLE;
        else if (hs && last_byte) state_d = FLUSH;
      end
      FLUSH:   state_d = abort ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_ready_q     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      words_written <= '0;
      ptr_q         <= '0;
      remaining_q   <= '0;
    end else begin
      s_ready_q <= (state_d == LOAD);
      busy      <= (state_d == LOAD) || (state_d == FLUSH);
      done      <= (state_d == DONE);
      wr_en     <= complete_c;
      if (start_acc) begin
        ptr_q         <= base_addr;
        remaining_q   <= length;
        words_written <= '0;
      end
      if (hs) remaining_q <= remaining_q - LEN_WIDTH'(1);
      if (complete_c) begin
        wr_addr <= ptr_q;
        wr_data <= word_c;
        ptr_q   <= ptr_q + ADDRESS_WIDTH'(1);
        if (words_written != WORDS_MAX) words_written <= words_written + (ADDRESS_WIDTH+1)'(1);
      end
    end
  end

`ifdef DPRAM_STREAM_LOADER_CHECKSUM_EN
  // Sum of accepted bytes only; pad lanes never pass through the handshake.
  always_ff @(posedge clock) begin
    if (!reset_n || start_acc) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + CHECKSUM_W'(s.s_data);
    end
  end
`endif

endmodule

// File: tb/tb_dpram_stream_loader.sv
// Directed bench for dpram_stream_loader (DATA_WIDTH=16, ADDRESS_WIDTH=10).
module tb_dpram_stream_loader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 16;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;
`ifdef DPRAM_STREAM_LOADER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  int checks = 0;
  int errors = 0;

  dpram_stream_loader_if sif ();

  dpram_stream_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .length        (length),
    .s             (sif),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
`ifdef DPRAM_STREAM_LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [63:0] addr,
                        input logic [63:0] data);
    chk({tag, ".wr_en"}, 64'(wr_en), 64'(en));
    if (en) begin
      chk({tag, ".wr_addr"}, 64'(wr_addr), addr);
      chk({tag, ".wr_data"}, 64'(wr_data), data);
    end
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [LW-1:0] n);
    start     = 1'b1;
    base_addr = b;
    length    = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    tick();
    sif.s_valid = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    base_addr   = '0;
    length      = '0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    tick();
    tick();
    chk("rst.s_ready", 64'(sif.s_ready), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk_wr("rst", 1'b0, 64'h0, 64'h0);
    chk("rst.wr_addr", 64'(wr_addr), 64'h0);
    chk("rst.wr_data", 64'(wr_data), 64'h0);
    chk("rst.words", 64'(words_written), 64'h0);
    reset_n = 1'b1;
    tick();

    // Four bytes back-to-back into two words.
    start_load(10'h010, 16'd4);
    chk("a.busy", 64'(busy), 64'(1));
    chk("a.s_ready", 64'(sif.s_ready), 64'(1));
    send(8'h11);
    chk_wr("a.b0", 1'b0, 64'h0, 64'h0);
    send(8'h22);
    chk_wr("a.w0", 1'b1, 64'h010, 64'h2211);
    send(8'h33);
    chk_wr("a.b2", 1'b0, 64'h0, 64'h0);
    chk("a.s_ready_mid", 64'(sif.s_ready), 64'(1));
    send(8'h44);
    chk_wr("a.w1", 1'b1, 64'h011, 64'h4433);
    chk("a.flush_ready", 64'(sif.s_ready), 64'(0));
    chk("a.flush_busy", 64'(busy), 64'(1));
    chk("a.flush_done", 64'(done), 64'(0));
    tick();
    chk("a.done", 64'(done), 64'(1));
    chk("a.done_busy", 64'(busy), 64'(0));
    chk("a.words", 64'(words_written), 64'd2);
    chk_wr("a.after", 1'b0, 64'h0, 64'h0);
    chk("a.hold_addr", 64'(wr_addr), 64'h011);
    chk("a.hold_data", 64'(wr_data), 64'h4433);
    tick();
    chk("a.done_pulse", 64'(done), 64'(0));

    // Odd length pads the last word; a start while busy is ignored.
    start_load(10'h020, 16'd3);
    start     = 1'b1;
    base_addr = 10'h003;
    length    = 16'd1;
    send(8'hAA);
    start = 1'b0;
    send(8'hBB);
    chk_wr("b.w0", 1'b1, 64'h020, 64'hBBAA);
    send(8'hCC);
    chk_wr("b.w1", 1'b1, 64'h021, 64'h00CC);
    tick();
    chk("b.done", 64'(done), 64'(1));
    chk("b.words", 64'(words_written), 64'd2);
    tick();
    chk("b.done_once", 64'(done), 64'(0));

    // Address pointer wraps past the top of the RAM.
    start_load(10'h3FF, 16'd4);
    send(8'h01);
    send(8'h02);
    chk_wr("c.w0", 1'b1, 64'h3FF, 64'h0201);
    send(8'h03);
    send(8'h04);
    chk_wr("c.w1", 1'b1, 64'h000, 64'h0403);
    tick();
    chk("c.done", 64'(done), 64'(1));
    chk("c.words", 64'(words_written), 64'd2);
    tick();

    // Gapped valid: ready stays high, single write after second handshake.
    start_load(10'h050, 16'd2);
    send(8'h5A);
    chk_wr("d.b0", 1'b0, 64'h0, 64'h0);
    tick();
    chk("d.gap_ready", 64'(sif.s_ready), 64'(1));
    chk_wr("d.gap", 1'b0, 64'h0, 64'h0);
    send(8'hA5);
    chk_wr("d.w0", 1'b1, 64'h050, 64'hA55A);
    tick();
    chk("d.done", 64'(done), 64'(1));
    tick();

    // Abort after three bytes: one write, partial word lost, no done.
    start_load(10'h100, 16'd8);
    send(8'h01);
    send(8'h02);
    chk_wr("e.w0", 1'b1, 64'h100, 64'h0201);
    send(8'h03);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("e.abort_busy", 64'(busy), 64'(0));
    chk("e.abort_ready", 64'(sif.s_ready), 64'(0));
    chk("e.abort_done", 64'(done), 64'(0));
    chk_wr("e.abort", 1'b0, 64'h0, 64'h0);
    tick();
    chk("e.idle_done", 64'(done), 64'(0));
    chk("e.words", 64'(words_written), 64'd1);
    start_load(10'h200, 16'd0);
    chk("e.empty_done", 64'(done), 64'(1));
    chk_wr("e.empty", 1'b0, 64'h0, 64'h0);
    chk("e.empty_words", 64'(words_written), 64'd0);
    tick();
    chk("e.empty_pulse", 64'(done), 64'(0));

`ifdef DPRAM_STREAM_LOADER_CHECKSUM_EN
    // Checksum excludes pad byte of the final word.
    start_load(10'h030, 16'd3);
    chk("f.cks_clear", 64'(checksum), 64'h0);
    send(8'hFF);
    send(8'hFF);
    send(8'h02);
    tick();
    chk("f.done", 64'(done), 64'(1));
    chk("f.checksum", 64'(checksum), 64'h0200);
    tick();
    chk("f.cks_hold", 64'(checksum), 64'h0200);
`endif

    // Reset in the middle of a load clears every output.
    start_load(10'h040, 16'd4);
    send(8'h11);
    send(8'h22);
    chk_wr("g.w0", 1'b1, 64'h040, 64'h2211);
    reset_n     = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data  = 8'h33;
    tick();
    sif.s_valid = 1'b0;
    chk("g.s_ready", 64'(sif.s_ready), 64'(0));
    chk("g.busy", 64'(busy), 64'(0));
    chk("g.wr_en", 64'(wr_en), 64'(0));
    chk("g.wr_addr", 64'(wr_addr), 64'h0);
    chk("g.wr_data", 64'(wr_data), 64'h0);
    chk("g.words", 64'(words_written), 64'h0);
`ifdef DPRAM_STREAM_LOADER_CHECKSUM_EN
    chk("g.checksum", 64'(checksum), 64'h0);
`endif
    reset_n = 1'b1;
    tick();
    chk("g.idle_ready", 64'(sif.s_ready), 64'(0));
    chk("g.idle_done", 64'(done), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
